// File: rtl/temp_display_pkg.sv
// Shared types and constants for the Fahrenheit display driver:
// converter FSM states, seven-segment glyphs (active-low, g..a) and slot count.
package temp_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam int NUM_SLOTS = 4;

  // Double-dabble correction: a BCD nibble of 5 or more would overflow
  // past 9 after the next doubling, so pre-add 3.
  function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  // Decimal digit to glyph; anything outside 0..9 renders blank.
  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = SEG_0;
      4'd1:    g = SEG_1;
      4'd2:    g = SEG_2;
      4'd3:    g = SEG_3;
      4'd4:    g = SEG_4;
      4'd5:    g = SEG_5;
      4'd6:    g = SEG_6;
      4'd7:    g = SEG_7;
      4'd8:    g = SEG_8;
      4'd9:    g = SEG_9;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/temp_display_driver_bin2bcd_dd.sv
// Sequential double-dabble: 8-bit binary to three BCD digits in 8 shift cycles.
// result holds the scratch register; it is only meaningful while done=1.
module bin2bcd_dd
  import temp_display_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  din,
  output logic        busy,
  output logic        done,
  output logic [11:0] result
);

  conv_state_t state, state_next;
  logic [7:0]  shreg;
  logic [11:0] scratch;
  logic [11:0] adj;
  logic [2:0]  iter;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state: eight SHIFT iterations (iter 0..7), then one DONE cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (iter == 3'd7) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Add-3 correction on every scratch nibble ahead of the shift
  always_comb begin
    adj = {dd_adjust(scratch[11:8]), dd_adjust(scratch[7:4]), dd_adjust(scratch[3:0])};
  end

  // Shift datapath: load on start, then shift corrected scratch and operand left
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      scratch <= '0;
      iter    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= din;
            scratch <= '0;
            iter    <= '0;
          end
        end
        SHIFT: begin
          {scratch, shreg} <= {adj, shreg} << 1;
          iter             <= iter + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign result = scratch;

endmodule

// File: rtl/temp_display_driver.sv
// Fahrenheit display driver: converts the 8-bit value to BCD and scans it onto
// a 4-digit common-anode display as [hundreds][tens][ones][F].
module temp_display_driver
  import temp_display_pkg::*;
#(
  parameter int REFRESH_DIV   = 100000,
  parameter int BLANK_LEADING = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        bcd_valid,
  output logic [11:0] bcd,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int                CNT_W     = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [1:0]        SLOT_LAST = 2'(NUM_SLOTS - 1);

  logic        conv_busy;
  logic        conv_done;
  logic [11:0] conv_result;
  logic [11:0] disp;
  logic [CNT_W-1:0] cnt;
  logic        tick;
  logic [1:0]  slot, slot_next;
  logic [6:0]  glyph_next;
  logic        hide_h, hide_t;

  bin2bcd_dd u_conv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (in_valid),
    .din    (in_data),
    .busy   (conv_busy),
    .done   (conv_done),
    .result (conv_result)
  );

  assign in_ready = ~conv_busy;
  assign dp       = 1'b1;

  // Latch a finished conversion into the bcd output and the display register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd       <= '0;
      disp      <= '0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= conv_done;
      if (conv_done) begin
        bcd  <= conv_result;
        disp <= conv_result;
      end
    end
  end

  // Refresh counter: one tick every REFRESH_DIV cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CNT_W'(1);
  end

  assign tick      = (cnt == CNT_MAX);
  assign slot_next = (slot == SLOT_LAST) ? 2'd0 : slot + 2'd1;

  // Leading-zero blanking and glyph selection for the slot about to be shown
  always_comb begin
    hide_h     = (BLANK_LEADING != 0) && (disp[11:8] == 4'd0);
    hide_t     = hide_h && (disp[7:4] == 4'd0);
    glyph_next = SEG_BLANK;
    case (slot_next)
      2'd0:    glyph_next = SEG_F;
      2'd1:    glyph_next = digit_glyph(disp[3:0]);
      2'd2:    glyph_next = hide_t ? SEG_BLANK : digit_glyph(disp[7:4]);
      default: glyph_next = hide_h ? SEG_BLANK : digit_glyph(disp[11:8]);
    endcase
  end

  // Scan register: advance slot and register an/seg together on each tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= SLOT_LAST;
      an   <= 4'b1111;
      seg  <= SEG_BLANK;
    end else if (tick) begin
      slot <= slot_next;
      an   <= ~(4'b0001 << slot_next);
      seg  <= glyph_next;
    end
  end

endmodule

// File: tb/tb_temp_display_driver.sv
// Self-checking bench for temp_display_driver with REFRESH_DIV=4.
module tb_temp_display_driver;

  localparam int RD = 4;
  localparam logic [6:0] G_F  = 7'b0001110;
  localparam logic [6:0] G_BL = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, bcd_valid, dp;
  logic [11:0] bcd;
  logic [3:0]  an;
  logic [6:0]  seg;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // scoreboard: expectations from the stimulus side, observations from the monitor
  logic [11:0] exp_q[$];
  int          acc_q[$];
  logic [11:0] obs_bcd[256];
  int          obs_cyc[256];
  int          obs_n = 0;
  int          rd = 0;

  typedef struct {
    logic [7:0]  din;
    logic [11:0] bcd;
    logic [6:0]  h, t, o;
  } vec_t;
  vec_t vecs[8];

  temp_display_driver #(.REFRESH_DIV(RD), .BLANK_LEADING(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .bcd_valid(bcd_valid), .bcd(bcd),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (rst_n && bcd_valid && obs_n < 256) begin
      obs_bcd[obs_n] = bcd;
      obs_cyc[obs_n] = cycle;
      obs_n = obs_n + 1;
    end
  end

  function automatic logic [11:0] bcd_model(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drain();
    logic [11:0] eb;
    int ea;
    while (rd < obs_n) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: actual bcd_valid pulse bcd=%0h required none", obs_bcd[rd]);
      end else begin
        eb = exp_q.pop_front();
        ea = acc_q.pop_front();
        check("sb_bcd", 32'(obs_bcd[rd]), 32'(eb));
        check("sb_latency", 32'(obs_cyc[rd] - ea), 32'd9);
      end
      rd++;
    end
  endtask

  // called at posedge+1; holds in_valid until the accepting edge, then drops it
  task automatic send(input logic [7:0] v);
    int n;
    n = 0;
    in_data  = v;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    exp_q.push_back(bcd_model(int'(v)));
    acc_q.push_back(cycle);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!bcd_valid && n < 40) begin @(posedge clk); #1; n++; end
    if (!bcd_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: actual no bcd_valid required pulse", name);
    end
  endtask

  initial begin
    logic [3:0] an_seq[5];
    logic [6:0] seg_seq[5];
    logic [3:0] prev;
    logic [6:0] s0, s1, s2, s3;
    int last, k, lows, n0, n;

    vecs[0] = '{8'd0,   12'h000, G_BL,        G_BL,        7'b1000000};
    vecs[1] = '{8'd9,   12'h009, G_BL,        G_BL,        7'b0010000};
    vecs[2] = '{8'd40,  12'h040, G_BL,        7'b0011001,  7'b1000000};
    vecs[3] = '{8'd105, 12'h105, 7'b1111001,  7'b1000000,  7'b0010010};
    vecs[4] = '{8'd212, 12'h212, 7'b0100100,  7'b1111001,  7'b0100100};
    vecs[5] = '{8'd255, 12'h255, 7'b0100100,  7'b0010010,  7'b0010010};
    vecs[6] = '{8'd187, 12'h187, 7'b1111001,  7'b0000000,  7'b1111000};
    vecs[7] = '{8'd63,  12'h063, G_BL,        7'b0000010,  7'b0110000};
    an_seq  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    seg_seq = '{G_F, 7'b1000000, G_BL, G_BL, G_F};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'(G_BL));
    check("rst_dp", 32'(dp), 32'd1);
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_bcd_valid", 32'(bcd_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // scan order and timing from reset: first tick after 4 edges lights F
    prev = an; last = 0; k = 0;
    for (int e = 1; e <= 30 && k < 5; e++) begin
      @(posedge clk); #1;
      if (an !== prev) begin
        check($sformatf("scan_an%0d", k), 32'(an), 32'(an_seq[k]));
        check($sformatf("scan_gap%0d", k), 32'(e - last), 32'd4);
        check($sformatf("scan_seg%0d", k), 32'(seg), 32'(seg_seq[k]));
        last = e; prev = an; k++;
      end
    end
    check("scan_transitions", 32'(k), 32'd5);

    // 212: in_ready low for 9 cycles, bcd_valid right after it returns
    in_data = 8'd212; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back(bcd_model(212));
    acc_q.push_back(cycle);
    lows = 0;
    while (!in_ready && lows < 30) begin lows++; @(posedge clk); #1; end
    check("busy_cycles", 32'(lows), 32'd9);
    check("valid_212", 32'(bcd_valid), 32'd1);
    check("bcd_212", 32'(bcd), 32'h212);
    @(posedge clk); #1;
    check("valid_pulse_212", 32'(bcd_valid), 32'd0);
    drain();

    // table: conversion result plus one full scan of the display
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].din);
      wait_valid($sformatf("vec%0d", i));
      check($sformatf("vec%0d_bcd", i), 32'(bcd), 32'(vecs[i].bcd));
      repeat (8 * RD) @(posedge clk);
      #1;
      s0 = 'x; s1 = 'x; s2 = 'x; s3 = 'x;
      for (int c = 0; c <= 4 * RD; c++) begin
        @(posedge clk); #1;
        case (an)
          4'b1110: s0 = seg;
          4'b1101: s1 = seg;
          4'b1011: s2 = seg;
          4'b0111: s3 = seg;
          default: ;
        endcase
      end
      check($sformatf("vec%0d_segF", i), 32'(s0), 32'(G_F));
      check($sformatf("vec%0d_seg_ones", i), 32'(s1), 32'(vecs[i].o));
      check($sformatf("vec%0d_seg_tens", i), 32'(s2), 32'(vecs[i].t));
      check($sformatf("vec%0d_seg_hund", i), 32'(s3), 32'(vecs[i].h));
      drain();
    end

    // back-to-back 255 then 7 with in_valid held
    n0 = obs_n;
    in_data = 8'd255; in_valid = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(bcd_model(255));
    acc_q.push_back(cycle);
    in_data = 8'd7;
    n = 0;
    while (!in_ready && n < 30) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    exp_q.push_back(bcd_model(7));
    acc_q.push_back(cycle);
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("b2b_pulses", 32'(obs_n - n0), 32'd2);
    if (obs_n - n0 == 2)
      check("b2b_gap", 32'(obs_cyc[obs_n - 1] - obs_cyc[obs_n - 2]), 32'd10);
    drain();
    check("b2b_pending", 32'(exp_q.size()), 32'd0);

    // reset 4 cycles into a conversion of 99
    n0 = obs_n;
    in_data = 8'd99; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_an", 32'(an), 32'hF);
    check("abort_bcd", 32'(bcd), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_seg", 32'(seg), 32'(G_BL));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_pulse", 32'(obs_n - n0), 32'd0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
